// File: rtl/alu_pipe_if.sv
// ============================================================================
// Module      : alu_pipe_if
// Description : Handshake and data bundle for the pipelined ALU. The master
//               side presents operations and accepts results; the slave side
//               is the ALU itself.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_pipe_if #(
  parameter int WIDTH = 16
);

  // Upstream (operation) channel
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             zx;
  logic             nx;
  logic             zy;
  logic             ny;
  logic             f;
  logic             no;
  logic             acc_en;
  logic             acc_clr;

  // Downstream (result) channel
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zr;
  logic             ng;
  logic             cy;
  logic             ov;

  modport master (
    output in_valid, x, y, zx, nx, zy, ny, f, no, acc_en, acc_clr, out_ready,
    input  in_ready, out_valid, out, zr, ng, cy, ov
  );

  modport slave (
    input  in_valid, x, y, zx, nx, zy, ny, f, no, acc_en, acc_clr, out_ready,
    output in_ready, out_valid, out, zr, ng, cy, ov
  );

endinterface

`default_nettype wire

// File: rtl/alu_pipe.sv
// ============================================================================
// Module      : alu_pipe
// Description : Two-stage pipelined ALU with the classic zx/nx/zy/ny/f/no
//               control set, valid/ready handshakes on both sides, carry and
//               signed-overflow flags, and an accumulator that can stand in
//               for the x operand. WIDTH must be at least 2.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_pipe #(
  parameter int WIDTH = 16
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  alu_pipe_if.slave   bus
);

  localparam int MSB = WIDTH - 1;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] xs_q,       xs_d;
  logic [WIDTH-1:0] ys_q,       ys_d;
  logic             f_q,        f_d;
  logic             no_q,       no_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_q,       out_d;
  logic             zr_q,        zr_d;
  logic             ng_q,        ng_d;
  logic             cy_q,        cy_d;
  logic             ov_q,        ov_d;

  logic [WIDTH-1:0] acc_q,       acc_d;

  // --------------------------------------------------------------------------
  // Handshake control
  // --------------------------------------------------------------------------
  logic accept;
  logic s2_load;

  // Stage 2 may take stage 1 when the output slot is empty or being drained.
  assign s2_load = s1_valid_q && (!bus.out_valid || bus.out_ready);

  // An accumulator op must wait for stage 1 to drain so acc already holds
  // the result of every earlier op when it is sampled.
  assign bus.in_ready = rst_n && (!s1_valid_q || s2_load)
                              && !(bus.acc_en && s1_valid_q);

  assign accept = bus.in_valid && bus.in_ready;

  // --------------------------------------------------------------------------
  // Stage 1 operand preprocessing
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] xs_pre;
  logic [WIDTH-1:0] ys_pre;

  // Select x source, then apply zero/negate controls to each operand.
  always_comb begin
    xs_pre = bus.acc_en ? acc_q : bus.x;
    if (bus.zx) xs_pre = '0;
    if (bus.nx) xs_pre = ~xs_pre;
    ys_pre = bus.y;
    if (bus.zy) ys_pre = '0;
    if (bus.ny) ys_pre = ~ys_pre;
  end

  // --------------------------------------------------------------------------
  // Stage 2 function evaluation
  // --------------------------------------------------------------------------
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] func_r;
  logic             func_cy;
  logic             func_ov;
  logic [WIDTH-1:0] result;

  // Add or AND the registered operands; carry/overflow only exist for add.
  always_comb begin
    sum     = {1'b0, xs_q} + {1'b0, ys_q};
    func_r  = xs_q & ys_q;
    func_cy = 1'b0;
    func_ov = 1'b0;
    if (f_q) begin
      func_r  = sum[MSB:0];
      func_cy = sum[WIDTH];
      func_ov = (xs_q[MSB] == ys_q[MSB]) && (sum[MSB] != xs_q[MSB]);
    end
    result = no_q ? ~func_r : func_r;
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------

  // Compute next values for both pipeline stages and the accumulator.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    xs_d        = xs_q;
    ys_d        = ys_q;
    f_d         = f_q;
    no_d        = no_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    zr_d        = zr_q;
    ng_d        = ng_q;
    cy_d        = cy_q;
    ov_d        = ov_q;
    acc_d       = acc_q;

    // Stage 1: capture on accept, otherwise empty out when stage 2 takes it.
    if (accept) begin
      s1_valid_d = 1'b1;
      xs_d       = xs_pre;
      ys_d       = ys_pre;
      f_d        = bus.f;
      no_d       = bus.no;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    // Stage 2: load a new result, or retire the current one when consumed.
    if (s2_load) begin
      out_valid_d = 1'b1;
      out_d       = result;
      zr_d        = (result == '0);
      ng_d        = result[MSB];
      cy_d        = func_cy;
      ov_d        = func_ov;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    // Accumulator: clear wins over tracking a coincident result.
    if (bus.acc_clr) begin
      acc_d = '0;
    end else if (s2_load) begin
      acc_d = result;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------

  // Pipeline and accumulator flops, flushed by asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      xs_q        <= '0;
      ys_q        <= '0;
      f_q         <= 1'b0;
      no_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      zr_q        <= 1'b0;
      ng_q        <= 1'b0;
      cy_q        <= 1'b0;
      ov_q        <= 1'b0;
      acc_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      xs_q        <= xs_d;
      ys_q        <= ys_d;
      f_q         <= f_d;
      no_q        <= no_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      zr_q        <= zr_d;
      ng_q        <= ng_d;
      cy_q        <= cy_d;
      ov_q        <= ov_d;
      acc_q       <= acc_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.zr        = zr_q;
  assign bus.ng        = ng_q;
  assign bus.cy        = cy_q;
  assign bus.ov        = ov_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_pipe.sv
// ============================================================================
// Module      : tb_alu_pipe
// Description : Directed self-checking bench for alu_pipe (WIDTH=16 and 8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_pipe;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_pipe_if #(.WIDTH(16)) bus16 ();
  alu_pipe_if #(.WIDTH(8))  bus8  ();

  alu_pipe #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  alu_pipe #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  localparam logic [5:0] OP_ADD  = 6'b000010;
  localparam logic [5:0] OP_SUB  = 6'b010011;
  localparam logic [5:0] OP_AND  = 6'b000000;
  localparam logic [5:0] OP_ZERO = 6'b101010;
  localparam logic [5:0] OP_NADD = 6'b000011;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [5:0] c, input logic [15:0] xv, input logic [15:0] yv,
                        input logic ae, input logic v);
    {bus16.zx, bus16.nx, bus16.zy, bus16.ny, bus16.f, bus16.no} = c;
    bus16.x        = xv;
    bus16.y        = yv;
    bus16.acc_en   = ae;
    bus16.in_valid = v;
  endtask

  // One isolated op: present, check acceptance, then wait for the result.
  task automatic run_op(input string tag, input logic [5:0] c, input logic [15:0] xv,
                        input logic [15:0] yv, input logic ae);
    set_op(c, xv, yv, ae, 1'b1);
    #1;
    chk({tag, "_rdy"}, 32'(bus16.in_ready), 32'd1);
    tick();
    bus16.in_valid = 1'b0;
    bus16.acc_en   = 1'b0;
    tick();
    chk({tag, "_vld"}, 32'(bus16.out_valid), 32'd1);
  endtask

  function automatic logic [31:0] flags16();
    return 32'({bus16.zr, bus16.ng, bus16.cy, bus16.ov});
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    set_op(6'b0, 16'd0, 16'd0, 1'b0, 1'b0);
    bus16.acc_clr   = 1'b0;
    bus16.out_ready = 1'b1;
    bus8.in_valid = 1'b0; bus8.x = '0; bus8.y = '0;
    {bus8.zx, bus8.nx, bus8.zy, bus8.ny, bus8.f, bus8.no} = 6'b0;
    bus8.acc_en = 1'b0; bus8.acc_clr = 1'b0; bus8.out_ready = 1'b1;

    // Reset state, in_ready held low even with a request pending
    #3;
    bus16.in_valid = 1'b1;
    #1;
    chk("rst_in_ready",  32'(bus16.in_ready),  32'd0);
    chk("rst_out_valid", 32'(bus16.out_valid), 32'd0);
    chk("rst_out",       32'(bus16.out),       32'd0);
    chk("rst_flags",     flags16(),            32'd0);
    bus16.in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // Back-to-back ops, x=9 y=15
    set_op(OP_ADD, 16'd9, 16'd15, 1'b0, 1'b1);
    #1;
    chk("b2b_rdy", 32'(bus16.in_ready), 32'd1);
    tick();
    chk("b2b_latency", 32'(bus16.out_valid), 32'd0);
    set_op(OP_SUB, 16'd9, 16'd15, 1'b0, 1'b1);
    tick();
    chk("add_vld",   32'(bus16.out_valid), 32'd1);
    chk("add_out",   32'(bus16.out),       32'd24);
    chk("add_flags", flags16(),            32'b0000);
    set_op(OP_AND, 16'd9, 16'd15, 1'b0, 1'b1);
    tick();
    chk("sub_out",   32'(bus16.out), 32'hFFFA);
    chk("sub_zr_ng", 32'({bus16.zr, bus16.ng}), 32'b01);
    set_op(OP_ZERO, 16'd9, 16'd15, 1'b0, 1'b1);
    tick();
    chk("and_out",   32'(bus16.out), 32'd9);
    chk("and_flags", flags16(),      32'b0000);
    bus16.in_valid = 1'b0;
    tick();
    chk("zero_out",   32'(bus16.out), 32'd0);
    chk("zero_flags", flags16(),      32'b1000);
    tick();
    chk("b2b_drained", 32'(bus16.out_valid), 32'd0);

    // Flag boundaries
    run_op("ovf", OP_ADD, 16'd32767, 16'd1, 1'b0);
    chk("ovf_out",   32'(bus16.out), 32'h8000);
    chk("ovf_flags", flags16(),      32'b0101);
    run_op("cy", OP_ADD, 16'hFFFF, 16'd1, 1'b0);
    chk("cy_out",   32'(bus16.out), 32'd0);
    chk("cy_flags", flags16(),      32'b1010);
    run_op("ncy", OP_NADD, 16'hFFFF, 16'd1, 1'b0);
    chk("ncy_out",   32'(bus16.out), 32'hFFFF);
    chk("ncy_flags", flags16(),      32'b0110);
    tick();

    // Accumulate: clear, then acc+5 three times
    bus16.acc_clr = 1'b1;
    tick();
    bus16.acc_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_op(OP_ADD, 16'hDEAD, 16'd5, 1'b1, 1'b1);
      #1;
      chk("acc_rdy", 32'(bus16.in_ready), 32'd1);
      tick();
      chk("acc_wait", 32'(bus16.in_ready), 32'd0);
      tick();
      chk("acc_out", 32'(bus16.out), 32'(5 * (i + 1)));
    end
    bus16.in_valid = 1'b0;
    bus16.acc_en   = 1'b0;
    tick();

    // Backpressure: A=3, B=30, C=300
    bus16.out_ready = 1'b0;
    set_op(OP_ADD, 16'd1, 16'd2, 1'b0, 1'b1);
    tick();
    set_op(OP_ADD, 16'd10, 16'd20, 1'b0, 1'b1);
    #1;
    chk("bp_rdy_b", 32'(bus16.in_ready), 32'd1);
    tick();
    set_op(OP_ADD, 16'd100, 16'd200, 1'b0, 1'b1);
    #1;
    chk("bp_rdy_c", 32'(bus16.in_ready), 32'd0);
    chk("bp_out_a", 32'(bus16.out),      32'd3);
    tick();
    chk("bp_hold_a",   32'(bus16.out),       32'd3);
    chk("bp_hold_vld", 32'(bus16.out_valid), 32'd1);
    bus16.out_ready = 1'b1;
    #1;
    chk("bp_rdy_rel", 32'(bus16.in_ready), 32'd1);
    tick();
    bus16.in_valid = 1'b0;
    chk("bp_out_b", 32'(bus16.out), 32'd30);
    tick();
    chk("bp_out_c", 32'(bus16.out), 32'd300);
    tick();
    chk("bp_drained", 32'(bus16.out_valid), 32'd0);

    // acc_clr coincident with the stage-2 load of 3+4
    set_op(OP_ADD, 16'd3, 16'd4, 1'b0, 1'b1);
    tick();
    bus16.in_valid = 1'b0;
    bus16.acc_clr  = 1'b1;
    tick();
    bus16.acc_clr = 1'b0;
    chk("clr_out", 32'(bus16.out), 32'd7);
    tick();
    run_op("clr_acc", OP_ADD, 16'd0, 16'd0, 1'b1);
    chk("clr_acc_out", 32'(bus16.out), 32'd0);
    tick();

    // Asynchronous reset with two ops in flight
    bus16.out_ready = 1'b0;
    set_op(OP_ADD, 16'd1, 16'd1, 1'b0, 1'b1);
    tick();
    set_op(OP_ADD, 16'd2, 16'd2, 1'b0, 1'b1);
    tick();
    bus16.in_valid = 1'b0;
    chk("mid_pre_out", 32'(bus16.out), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_out_valid", 32'(bus16.out_valid), 32'd0);
    chk("mid_out",       32'(bus16.out),       32'd0);
    chk("mid_acc",       32'(dut.acc_q),       32'd0);
    chk("mid_in_ready",  32'(bus16.in_ready),  32'd0);
    tick();
    rst_n = 1'b1;
    bus16.out_ready = 1'b1;
    tick();
    chk("post_rst_empty", 32'(bus16.out_valid), 32'd0);
    run_op("post", OP_ADD, 16'd9, 16'd15, 1'b0);
    chk("post_out", 32'(bus16.out), 32'd24);
    tick();
    chk("post_only_one", 32'(bus16.out_valid), 32'd0);

    // WIDTH=8 overflow
    {bus8.zx, bus8.nx, bus8.zy, bus8.ny, bus8.f, bus8.no} = OP_ADD;
    bus8.x = 8'd127;
    bus8.y = 8'd1;
    bus8.in_valid = 1'b1;
    #1;
    chk("w8_rdy", 32'(bus8.in_ready), 32'd1);
    tick();
    bus8.in_valid = 1'b0;
    tick();
    chk("w8_out",   32'(bus8.out), 32'h80);
    chk("w8_flags", 32'({bus8.zr, bus8.ng, bus8.cy, bus8.ov}), 32'b0101);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined successor to the combinational ALU16 (zx/nx/zy/ny/f/no control set).
- Adds valid/ready handshakes on both sides, carry and signed-overflow flags, and an internal accumulator that can replace the x operand.
- Sits between the operand/decode logic and the register write-back of the CPU datapath.

Parameters:
- WIDTH, 16, operand/result width in bits; must be at least 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation presented
- in_ready  output  1  operation accepted this cycle when in_valid&&in_ready
- x  input  WIDTH  operand x (two's complement)
- y  input  WIDTH  operand y
- zx,nx,zy,ny,f,no  input  1 each  control bits, classic ALU semantics
- acc_en  input  1  use accumulator instead of x
- acc_clr  input  1  synchronous accumulator clear
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts
- out  output  WIDTH  result
- zr  output  1  out==0
- ng  output  1  out[WIDTH-1]
- cy  output  1  carry out of adder
- ov  output  1  signed overflow of adder

Behaviour:
- Reset (rst_n low, asynchronous): s1_valid=0, out_valid=0, out=0, zr=0, ng=0, cy=0, ov=0, acc=0; in_ready forced 0 while rst_n low.
- Stage 1 (on input accept), registers preprocessed operands:
  - xs = acc_en ? acc : x; xs = zx ? 0 : xs; xs = nx ? ~xs : xs.
  - Same for y using zy/ny (no acc path).
  - Registers f and no; sets s1_valid.
- Stage 2 load condition: s2_load = s1_valid && (!out_valid || out_ready).
- Stage 2 (on s2_load), computes and registers:
  - f=1: sum = xs+ys in WIDTH+1 bits; cy = sum[WIDTH]; ov = (xs[MSB]==ys[MSB]) && (sum[MSB]!=xs[MSB]).
  - f=0: r = xs&ys; cy=0, ov=0.
  - out = no ? ~r : r.
  - zr, ng derived from the final out. cy/ov are not affected by no.
  - out_valid=1.
- Stage 1 clears when s2_load occurs without a new accept.
- out_valid clears on out_valid&&out_ready with no simultaneous s2_load.
- in_ready = rst_n && (!s1_valid || s2_load) && !(acc_en && s1_valid).
  - An acc_en op waits until stage 1 is empty, guaranteeing acc holds the result of every earlier op.
- Latency: accept at edge N -> out_valid at edge N+1. Full throughput of 1 op/cycle when out_ready is held high.
- Backpressure: out_ready=0 with out_valid=1 holds out and the flags stable. Stage 1 fills, then in_ready drops. No op is lost, duplicated or reordered.
- Accumulator:
  - acc <= new out on every s2_load.
  - acc_clr=1 sets acc=0 at the edge and has priority over a coincident s2_load. The coincident result is still delivered on out.
- in_valid without in_ready: inputs ignored, no state change. Inputs need not be held stable across stalls.
- Width rules: all arithmetic is modulo 2^WIDTH. There is no saturation.
- Reset mid-operation flushes both stages. Results in flight are discarded, and the first post-reset output comes from the first post-reset accept.

Test Plan:
- WIDTH=16, x=9, y=15, out_ready=1, back-to-back accepts:
  - x+y (000010) -> 24, zr0 ng0 cy0 ov0.
  - x-y (010011) -> -6, ng1.
  - x&y (000000) -> 9.
  - 0 (101010) -> 0, zr1.
  - Results appear on consecutive cycles, one cycle after accept.
- Flags:
  - x=32767, y=1, add -> out=-32768, ov1 ng1 cy0.
  - x=-1, y=1, add -> out=0, zr1 cy1 ov0.
  - x=-1, y=1, add with no=1 -> out=-1, cy1 unchanged.
- Accumulate: acc_clr pulse, then three acc_en ops with y=5, add (zx0 nx0 zy0 ny0 f1 no0) -> outputs 5, 10, 15.
  - Each acc_en op sees in_ready low while stage 1 is occupied.
- Backpressure: out_ready=0, issue ops A, B, C -> in_ready drops after B, out holds A.
  - Release out_ready -> A, B, C delivered in order, each exactly once.
- acc_clr coincident with s2_load of result 7 -> out=7 delivered; next acc_en add y=0 yields 0.
- Reset asserted asynchronously with two ops in flight -> outputs and acc read 0 immediately.
  - After release, a single x+y op with x=9, y=15 yields only 24.
- WIDTH=8 re-run: x=127, y=1, add -> -128, ov1.
